// File: rtl/midi_tx_queue_pkg.sv
// Shared definitions for the MIDI transmit queue: controller state encoding
// and the default sizing parameters.
package midi_tx_queue_pkg;

  localparam int unsigned ADDR_W_DEF   = 4;
  localparam int unsigned BUSY_TMO_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_STROBE    = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } tx_state_e;

endpackage

// File: rtl/midi_tx_queue_byte_fifo.sv
// byte_fifo: registered circular byte buffer with occupancy count,
// full/empty flags and a one-cycle pulse for every dropped write.
module byte_fifo
  import midi_tx_queue_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  input  logic              rd_en,
  output logic [7:0]        rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_overflow;
  logic              w_push;
  logic              w_pop;

  assign full     = (r_count == DEPTH_CNT);
  assign empty    = (r_count == '0);
  assign count    = r_count;
  assign overflow = r_overflow;
  assign rd_data  = r_mem[r_rd_ptr];

  // A write while full is dropped even if a pop happens in the same cycle.
  always_comb begin
    w_push = wr_en & ~full;
    w_pop  = rd_en & ~empty;
  end

  // Storage array; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // Pointers, occupancy and overflow pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= wr_en & full;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/midi_tx_queue.sv
// midi_tx_queue: byte queue between the MIDI router core and a UART
// transmitter. Each byte is launched with a one-cycle strobe, then the
// controller waits for the UART busy flag to rise and fall again.
module midi_tx_queue
  import midi_tx_queue_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int BUSY_TMO = BUSY_TMO_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              tx_strobe,
  output logic [7:0]        tx_data,
  input  logic              tx_busy,
  output logic              timeout
);

  localparam int TMO_W = $clog2(BUSY_TMO + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TMO - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);

  tx_state_e        r_state;
  tx_state_e        w_state_nxt;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic [TMO_W-1:0] w_tmo_cnt_nxt;
  logic             w_pop;
  logic             w_timeout_nxt;
  logic [7:0]       w_head;
  logic             r_tx_strobe;
  logic [7:0]       r_tx_data;
  logic             r_timeout;

  byte_fifo #(.ADDR_W(ADDR_W)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (w_pop),
    .rd_data  (w_head),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  assign tx_strobe = r_tx_strobe;
  assign tx_data   = r_tx_data;
  assign timeout   = r_timeout;

  // Next-state logic; a new byte is only launched while the UART is idle.
  always_comb begin
    w_state_nxt   = r_state;
    w_tmo_cnt_nxt = r_tmo_cnt;
    w_pop         = 1'b0;
    w_timeout_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!empty && !tx_busy) begin
          w_state_nxt = ST_STROBE;
          w_pop       = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_STROBE: begin
        w_state_nxt   = ST_WAIT_BUSY;
        w_tmo_cnt_nxt = '0;
      end
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          w_state_nxt = ST_WAIT_DONE;
        end else if (r_tmo_cnt == TMO_LAST) begin
          w_state_nxt   = ST_IDLE;
          w_timeout_nxt = 1'b1;
        end else begin
          w_tmo_cnt_nxt = r_tmo_cnt + TMO_ONE;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT_DONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register and registered UART-facing outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_tmo_cnt   <= '0;
      r_tx_strobe <= 1'b0;
      r_tx_data   <= 8'h00;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_tmo_cnt   <= w_tmo_cnt_nxt;
      r_tx_strobe <= (w_state_nxt == ST_STROBE);
      r_timeout   <= w_timeout_nxt;
      if (w_pop) begin
        r_tx_data <= w_head;
      end
    end
  end

endmodule

// File: tb/tb_midi_tx_queue.sv
// Self-checking bench for midi_tx_queue: per-cycle vector table for the
// single-byte and timeout timelines, then directed and random traffic checked
// against a queue-based reference model with a simple UART busy responder.
module tb_midi_tx_queue;

  localparam int DEPTH = 16;
  localparam int U_MAN = 0, U_AUTO = 1, U_STUCK = 2;

  logic       clk = 1'b0;
  logic       rst, wr_en, tx_busy;
  logic [7:0] wr_data;
  logic       full, empty, overflow, tx_strobe, timeout;
  logic [4:0] count;
  logic [7:0] tx_data;

  always #5 clk = ~clk;

  midi_tx_queue #(.ADDR_W(4), .BUSY_TMO(4)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .overflow(overflow),
    .tx_strobe(tx_strobe), .tx_data(tx_data), .tx_busy(tx_busy),
    .timeout(timeout)
  );

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       busy;
    logic       e_stb;
    logic [4:0] e_cnt;
    logic       e_emp;
    logic       e_tmo;
    logic [7:0] e_txd;
  } vec_t;

  vec_t       tv [15];
  int         n_tests = 0, n_fail = 0;
  logic [7:0] q [$];
  int         mc = 0, cyc = 0, umode = U_MAN, u_phase = 0, u_cnt = 0;
  int         last_fall = -1, ovf_seen = 0, strobe_seen = 0, peak = 0;
  bit         b2b_chk = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock with model update, output checks and UART responder.
  task automatic step();
    logic       p_wr, p_rst;
    logic [7:0] p_d;
    bit         acc, ovf_e;
    p_wr = wr_en; p_rst = rst; p_d = wr_data;
    @(posedge clk); #1; cyc++;
    acc   = !p_rst && p_wr && (mc < DEPTH);
    ovf_e = !p_rst && p_wr && (mc == DEPTH);
    if (p_rst) begin
      q.delete(); mc = 0;
      chk("strobe_after_rst", tx_strobe, 0);
    end
    if (acc) begin q.push_back(p_d); mc++; end
    if (tx_strobe) begin
      strobe_seen++;
      chk("strobe_while_busy", tx_busy, 0);
      if (q.size() == 0) chk("strobe_with_empty_queue", tx_strobe, 0);
      else begin chk("tx_data", tx_data, q.pop_front()); mc--; end
      if (b2b_chk && last_fall >= 0) chk("b2b_gap", cyc - last_fall, 2);
      last_fall = -1;
    end
    chk("count", count, mc);
    chk("full", full, (mc == DEPTH));
    chk("empty", empty, (mc == 0));
    chk("overflow", overflow, ovf_e);
    chk("timeout", timeout, 0);
    if (overflow) ovf_seen++;
    if (count > peak) peak = count;
    case (umode)
      U_AUTO: begin
        if (u_phase == 1) begin
          u_cnt--;
          if (u_cnt == 0) begin tx_busy = 1'b1; u_phase = 2; u_cnt = $urandom_range(1, 4); end
        end else if (u_phase == 2) begin
          u_cnt--;
          if (u_cnt == 0) begin tx_busy = 1'b0; u_phase = 0; last_fall = cyc; end
        end
        if (tx_strobe) begin u_phase = 1; u_cnt = $urandom_range(1, 3); end
      end
      U_STUCK: tx_busy = 1'b1;
      default: ;
    endcase
  endtask

  task automatic drain(input int budget);
    int n = 0;
    wr_en = 1'b0;
    while ((mc != 0 || u_phase != 0 || tx_busy) && n < budget) begin step(); n++; end
    repeat (3) step();
    chk("drain_empty", empty, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got time limit expected finish");
    $fatal(1);
  end

  initial begin
    int s0;
    // Reset with a write request that must be ignored.
    rst = 1'b1; wr_en = 1'b1; wr_data = 8'hAA; tx_busy = 1'b0;
    step(); step();
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_strobe", tx_strobe, 0);
    rst = 1'b0; wr_en = 1'b0;

    // Single byte (N+2 latency) followed by a timed-out byte.
    tv[0]  = '{1'b1, 8'h90, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 8'h00};
    tv[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 8'h90};
    tv[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 8'h90};
    tv[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 8'h90};
    tv[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 8'h90};
    tv[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 8'h90};
    tv[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 8'h90};
    tv[7]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 8'h90};
    tv[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 8'h3C};
    tv[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 8'h3C};
    tv[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 8'h3C};
    tv[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 8'h3C};
    tv[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 8'h3C};
    tv[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 8'h3C};
    tv[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 8'h3C};
    for (int i = 0; i < 15; i++) begin
      wr_en = tv[i].wr; wr_data = tv[i].d; tx_busy = tv[i].busy;
      @(posedge clk); #1; cyc++;
      chk($sformatf("vec%0d", i),
          {tx_strobe, count, empty, timeout, full, overflow, tx_data},
          {tv[i].e_stb, tv[i].e_cnt, tv[i].e_emp, tv[i].e_tmo, 1'b0, 1'b0, tv[i].e_txd});
    end
    wr_en = 1'b0; tx_busy = 1'b0;

    // Burst of three with back-to-back spacing checks.
    umode = U_AUTO; b2b_chk = 1'b1; last_fall = -1; peak = 0; s0 = strobe_seen;
    wr_en = 1'b1;
    wr_data = 8'h90; step();
    wr_data = 8'h3C; step();
    wr_data = 8'h7F; step();
    drain(200);
    b2b_chk = 1'b0;
    chk("burst_peak", peak, 2);
    chk("burst_strobes", strobe_seen - s0, 3);

    // Overflow: UART stuck busy, 17 writes.
    umode = U_STUCK; tx_busy = 1'b1; ovf_seen = 0;
    for (int i = 0; i < 17; i++) begin wr_en = 1'b1; wr_data = 8'h40 + 8'(i); step(); end
    wr_en = 1'b0; step();
    chk("ovf_count", count, 16);
    chk("ovf_full", full, 1);
    chk("ovf_pulses", ovf_seen, 1);
    umode = U_AUTO; tx_busy = 1'b0; u_phase = 0; s0 = strobe_seen;
    drain(600);
    chk("ovf_drained", strobe_seen - s0, 16);

    // Wrap: 40 sequential bytes, written whenever the queue has room.
    s0 = strobe_seen;
    begin
      int k = 0, guard = 0;
      while (k < 40 && guard < 2000) begin
        wr_en = (mc < DEPTH); wr_data = 8'(k);
        if (mc < DEPTH) k++;
        step(); guard++;
      end
    end
    drain(600);
    chk("wrap_strobes", strobe_seen - s0, 40);

    // Reset in WAIT_DONE with 3 bytes queued.
    umode = U_MAN; tx_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin wr_en = 1'b1; wr_data = 8'hA0 + 8'(i); step(); end
    wr_en = 1'b0; tx_busy = 1'b1;
    repeat (3) step();
    chk("pre_rst_count", count, 3);
    rst = 1'b1; step(); rst = 1'b0;
    chk("post_rst_count", count, 0);
    tx_busy = 1'b0; s0 = strobe_seen;
    repeat (10) step();
    chk("post_rst_no_strobe", strobe_seen - s0, 0);
    umode = U_AUTO; u_phase = 0;
    wr_en = 1'b1; wr_data = 8'h55; step();
    drain(100);
    chk("post_rst_new_byte", strobe_seen - s0, 1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      wr_en = ($urandom_range(0, 2) == 0); wr_data = 8'($urandom);
      step();
    end
    drain(1500);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/midi_tx_queue.md
MIDI_TX_QUEUE -- requirements
Module: midi_tx_queue

Interface
REQ-001 Parameter ADDR_W, default 4, FIFO address width; depth = 2**ADDR_W bytes.
REQ-002 Parameter BUSY_TMO, default 4, max clocks the block waits for tx_busy to rise after a strobe.
REQ-003 Port clk, input, 1, single clock; every register updates on its rising edge.
REQ-004 Port rst, input, 1, reset; synchronous, active-high.
REQ-005 Port wr_en, input, 1, byte-write request from the router core.
REQ-006 Port wr_data, input, 8, byte to enqueue.
REQ-007 Port full, output, 1, count == depth.
REQ-008 Port empty, output, 1, count == 0.
REQ-009 Port count, output, ADDR_W+1, number of stored bytes.
REQ-010 Port overflow, output, 1, one-cycle pulse: a write was dropped.
REQ-011 Port tx_strobe, output, 1, one-cycle launch pulse to the downstream UART transmitter.
REQ-012 Port tx_data, output, 8, byte presented to the UART; held stable from strobe until done.
REQ-013 Port tx_busy, input, 1, UART busy flag.
REQ-014 Port timeout, output, 1, one-cycle pulse: tx_busy never rose after a strobe.

Function
REQ-015 FIFO: registered circular buffer; write and read pointers are ADDR_W bits and wrap from depth-1 to 0.
REQ-016 Write: wr_en with full=0 stores wr_data at the write pointer; count and flags update on the next cycle.
REQ-017 Write while full: the byte is dropped, and overflow pulses in the following cycle; this holds even when a pop occurs in the same cycle.
REQ-018 Simultaneous write and pop with full=0: both take effect, and count is unchanged.
REQ-019 Controller states: IDLE, STROBE, WAIT_BUSY, WAIT_DONE.
REQ-020 IDLE -> STROBE when empty=0: on that edge, tx_data loads the FIFO head and the read pointer advances (pop).
REQ-021 STROBE: tx_strobe=1 for exactly one cycle, then go to WAIT_BUSY.
REQ-022 WAIT_BUSY -> WAIT_DONE on tx_busy=1.
REQ-023 WAIT_BUSY -> IDLE after BUSY_TMO cycles without tx_busy; timeout pulses and the byte is discarded.
REQ-024 WAIT_DONE -> IDLE on tx_busy=0.
REQ-025 Latency: a byte written in cycle N into an empty queue with the controller in IDLE gives tx_strobe=1 in cycle N+2.
REQ-026 Back-to-back: with data queued, the next tx_strobe follows 2 cycles after tx_busy falls (WAIT_DONE -> IDLE -> STROBE).
REQ-027 tx_strobe is never asserted while tx_busy=1 or while empty was 1 at the IDLE decision.
REQ-028 Undefined state encodings return to IDLE on the next cycle.

Reset
REQ-029 rst=1 at a clock edge sets: pointers=0, count=0, empty=1, full=0, overflow=0, timeout=0, tx_strobe=0, tx_data=8'h00, state=IDLE.
REQ-030 Reset mid-transfer discards all queued bytes and any byte in flight; no further strobe is issued until a new write.
REQ-031 wr_en is ignored in any cycle where rst=1.

Structure
REQ-032 A shared package holds the state encodings (2-bit) and the defaults for ADDR_W and BUSY_TMO.
REQ-033 The FIFO is a sub-module byte_fifo (storage, pointers, count, full/empty/overflow); midi_tx_queue instantiates it and holds the controller.

Verification
REQ-034 Single byte: write 8'h90 into an empty queue in cycle N -> tx_strobe in cycle N+2 with tx_data=8'h90; with busy model for 40 cycles, the state returns to IDLE and empty=1.
REQ-035 Burst: write 8'h90, 8'h3C, 8'h7F back-to-back -> three strobes in that order, each only after tx_busy fell; count peaks at 2.
REQ-036 Overflow: 17 writes with tx_busy held 1 -> count=16, full=1, one overflow pulse; the 17th byte is never transmitted.
REQ-037 Wrap: write and drain 40 bytes 8'h00..8'h27 -> output sequence is identical and the pointers wrapped at least twice.
REQ-038 Timeout: tx_busy tied 0 with one byte queued -> timeout pulses 5 cycles after the strobe; state is IDLE and empty=1.
REQ-039 Reset mid-transfer: rst=1 during WAIT_DONE with 3 bytes queued -> next cycle count=0, tx_strobe stays 0, and no strobe occurs until a new write.
